// File: rtl/gpio_apb_filt_gen2.sv
// gpio_apb_filt_gen2: APB GPIO bank with per-pin direction, masked half-word output
// writes, synchronised + debounced inputs and per-pin interrupt flags (W1C).
// Optional strap capture registers are built when GPIO_STRAP_EN is defined.
module gpio_apb_filt_gen2 #(
    parameter int unsigned NUM_PINS = 32,
    parameter int unsigned FILT_W   = 8,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [5:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    output logic                irq,
    input  logic                strap_en,
    inout  wire  [NUM_PINS-1:0] physical_pin
);

    typedef enum logic [3:0] {
        R_IN          = 4'h0,
        R_OUT         = 4'h1,
        R_MOUT_LO     = 4'h2,
        R_MOUT_HI     = 4'h3,
        R_DIR         = 4'h4,
        R_IE          = 4'h5,
        R_ITYPE_LO    = 4'h6,
        R_ITYPE_HI    = 4'h7,
        R_IFG         = 4'h8,
        R_FILT_TH     = 4'h9,
        R_STRAP_VALID = 4'hA,
        R_STRAP_DATA  = 4'hB
    } reg_e;

    function automatic logic [63:0] itype_mask_f();
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < NUM_PINS) m[2*i +: 2] = 2'b11;
        end
        return m;
    endfunction

    localparam logic [31:0] PIN_MASK   = (NUM_PINS >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << NUM_PINS) - 32'd1);
    localparam logic [63:0] ITYPE_MASK = itype_mask_f();

    reg_e              idx;
    logic              access;
    logic              wr;
    logic              err;
    logic [31:0]       rdata;
    logic [31:0]       out_q, dir_q, ie_q, ifg_q;
    logic [63:0]       itype_q;
    logic [FILT_W-1:0] th_q;
    logic [31:0]       in_ext;
    logic [31:0]       ev;
    logic [31:0]       w1c;
    logic [NUM_PINS-1:0] sync_q [SYNC_STG];
    logic [NUM_PINS-1:0] filt_q, filt_d_q;
    logic [FILT_W-1:0]   cnt_q [NUM_PINS];
    logic                unused_ok;

`ifdef GPIO_STRAP_EN
    logic              strap_valid_q;
    logic [31:0]       strap_data_q;
    assign unused_ok = ^PADDR[1:0];
`else
    assign unused_ok = ^{PADDR[1:0], strap_en};
`endif

    assign idx     = reg_e'(PADDR[5:2]);
    assign access  = PSEL & PENABLE;
    assign wr      = access & PWRITE & ~err;
    assign PREADY  = 1'b1;
    assign PSLVERR = access & err;
    assign PRDATA  = access ? rdata : '0;
    assign irq     = |(ifg_q & ie_q);

    // Pads are driven only where the direction bit is set
    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pad
        assign physical_pin[g] = dir_q[g] ? out_q[g] : 1'bz;
    end

    // Address decode: read mux and error classification
    always_comb begin
        err   = 1'b0;
        rdata = '0;
        in_ext = '0;
        in_ext[NUM_PINS-1:0] = filt_q;
        case (idx)
            R_IN:       begin rdata = in_ext; err = PWRITE; end
            R_OUT:      rdata = out_q;
            R_MOUT_LO,
            R_MOUT_HI:  rdata = '0;
            R_DIR:      rdata = dir_q;
            R_IE:       rdata = ie_q;
            R_ITYPE_LO: rdata = itype_q[31:0];
            R_ITYPE_HI: rdata = itype_q[63:32];
            R_IFG:      rdata = ifg_q;
            R_FILT_TH:  rdata = 32'(th_q);
`ifdef GPIO_STRAP_EN
            R_STRAP_VALID: rdata = {31'b0, strap_valid_q};
            R_STRAP_DATA:  begin rdata = strap_data_q; err = PWRITE; end
`else
            R_STRAP_VALID,
            R_STRAP_DATA:  err = 1'b1;
`endif
            default:    err = 1'b1;
        endcase
        if (err) rdata = '0;
    end

    // Configuration register writes; bits above NUM_PINS never stick
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            itype_q <= '0;
            th_q    <= '0;
        end else if (wr) begin
            case (idx)
                R_OUT:      out_q <= PWDATA & PIN_MASK;
                R_MOUT_LO:  out_q[15:0] <= ((out_q[15:0] & ~PWDATA[31:16]) |
                                            (PWDATA[15:0] & PWDATA[31:16])) & PIN_MASK[15:0];
                R_MOUT_HI:  out_q[31:16] <= ((out_q[31:16] & ~PWDATA[31:16]) |
                                             (PWDATA[15:0] & PWDATA[31:16])) & PIN_MASK[31:16];
                R_DIR:      dir_q <= PWDATA & PIN_MASK;
                R_IE:       ie_q <= PWDATA & PIN_MASK;
                R_ITYPE_LO: itype_q[31:0] <= PWDATA & ITYPE_MASK[31:0];
                R_ITYPE_HI: itype_q[63:32] <= PWDATA & ITYPE_MASK[63:32];
                R_FILT_TH:  th_q <= PWDATA[FILT_W-1:0];
                default:    ;
            endcase
        end
    end

    // Input synchroniser chain
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned s = 0; s < SYNC_STG; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= physical_pin;
            for (int unsigned s = 1; s < SYNC_STG; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Per-pin debounce; a counter above a lowered threshold keeps counting (wrapping) until it matches
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            filt_q   <= '0;
            filt_d_q <= '0;
            for (int unsigned i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
        end else begin
            filt_d_q <= filt_q;
            for (int unsigned i = 0; i < NUM_PINS; i++) begin
                if (sync_q[SYNC_STG-1][i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == th_q) begin
                    filt_q[i] <= sync_q[SYNC_STG-1][i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Interrupt event detection on the filtered input
    always_comb begin
        ev  = '0;
        w1c = (wr && idx == R_IFG) ? PWDATA : '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            case (itype_q[2*i +: 2])
                2'b00:   ev[i] = filt_q[i] & ~filt_d_q[i];
                2'b01:   ev[i] = ~filt_q[i] & filt_d_q[i];
                2'b10:   ev[i] = filt_q[i] ^ filt_d_q[i];
                default: ev[i] = filt_q[i];
            endcase
        end
    end

    // Interrupt flags: a new event wins over a same-cycle W1C
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) ifg_q <= '0;
        else          ifg_q <= (ifg_q & ~w1c) | (ev & ie_q);
    end

`ifdef GPIO_STRAP_EN
    // Strap capture: a capture pulse wins over a same-cycle W1C of the valid flag
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            strap_valid_q <= 1'b0;
            strap_data_q  <= '0;
        end else if (strap_en) begin
            strap_valid_q <= 1'b1;
            strap_data_q  <= in_ext;
        end else if (wr && idx == R_STRAP_VALID && PWDATA[0]) begin
            strap_valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_apb_filt_gen2.sv
// Scoreboard bench for gpio_apb_filt_gen2: stimulus pushes expected responses,
// a negedge monitor pops and compares on every APB access phase.
module tb_gpio_apb_filt_gen2;

    localparam int unsigned NP = 32;
    localparam int unsigned SS = 2;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [5:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA, prdata8;
    logic        PREADY, PSLVERR, irq, strap_en;
    logic        pready8, pslverr8, unused_irq8;
    wire  [NP-1:0] pins;
    wire  [7:0]    pins8;
    logic [NP-1:0] pad_drv, pad_en;

    gpio_apb_filt_gen2 #(.NUM_PINS(NP), .FILT_W(8), .SYNC_STG(SS)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .irq(irq), .strap_en(strap_en), .physical_pin(pins)
    );

    gpio_apb_filt_gen2 #(.NUM_PINS(8), .FILT_W(8), .SYNC_STG(SS)) u_dut8 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
        .irq(unused_irq8), .strap_en(strap_en), .physical_pin(pins8)
    );

    for (genvar g = 0; g < NP; g++) begin : g_drv
        assign pins[g] = pad_en[g] ? pad_drv[g] : 1'bz;
    end

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        rd;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        err;
        logic        irq;
        logic [31:0] pmask;
        logic [31:0] pval;
        logic        chk8;
        logic [31:0] data8;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (register view of the block)
    logic [31:0] m_out, m_dir, m_ie, m_ifg, m_in;
    logic [63:0] m_itype;
    logic [7:0]  m_th, m_out8;
    logic        m_sv;
    logic [31:0] m_sd;

    task automatic chk(input string name, input logic [5:0] a, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s addr=0x%02h got=0x%08h exp=0x%08h", name, a, act, exp);
        end
    endtask

    // Monitor: every access phase must match the oldest expectation
    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty addr=0x%02h got=access exp=none", PADDR);
            end else begin
                mon_e = sbq.pop_front();
                chk("pready", mon_e.addr, {31'b0, PREADY}, 32'd1);
                chk("pslverr", mon_e.addr, {31'b0, PSLVERR}, {31'b0, mon_e.err});
                chk("irq", mon_e.addr, {31'b0, irq}, {31'b0, mon_e.irq});
                if (mon_e.rd) chk("prdata", mon_e.addr, PRDATA, mon_e.data);
                if (mon_e.pmask != 0) chk("pads", mon_e.addr, pins & mon_e.pmask, mon_e.pval & mon_e.pmask);
                if (mon_e.chk8) begin
                    chk("prdata8", mon_e.addr, prdata8, mon_e.data8);
                    chk("pslverr8", mon_e.addr, {31'b0, pslverr8}, {31'b0, mon_e.err});
                end
            end
        end
    end

    function automatic logic [31:0] lvl_pins();
        logic [31:0] l;
        for (int i = 0; i < 32; i++) l[i] = &m_itype[2*i +: 2];
        return l;
    endfunction

    task automatic m_level();
        m_ifg = m_ifg | (m_ie & m_in & lvl_pins());
    endtask

    // Filtered input changes from m_in to nv; raise flags per interrupt type
    task automatic m_events(input logic [31:0] nv);
        logic r, f, e;
        for (int i = 0; i < 32; i++) begin
            r = nv[i] & ~m_in[i];
            f = ~nv[i] & m_in[i];
            case (m_itype[2*i +: 2])
                2'b00:   e = r;
                2'b01:   e = f;
                2'b10:   e = r | f;
                default: e = nv[i];
            endcase
            if (e && m_ie[i]) m_ifg[i] = 1'b1;
        end
        m_in = nv;
        m_level();
    endtask

    task automatic m_read(input logic [5:0] a, output logic [31:0] d, output logic e);
        d = '0;
        e = 1'b0;
        case (a[5:2])
            4'h0: d = m_in;
            4'h1: d = m_out;
            4'h2, 4'h3: d = '0;
            4'h4: d = m_dir;
            4'h5: d = m_ie;
            4'h6: d = m_itype[31:0];
            4'h7: d = m_itype[63:32];
            4'h8: d = m_ifg;
            4'h9: d = {24'b0, m_th};
`ifdef GPIO_STRAP_EN
            4'hA: d = {31'b0, m_sv};
            4'hB: d = m_sd;
`endif
            default: e = 1'b1;
        endcase
    endtask

    task automatic m_write(input logic [5:0] a, input logic [31:0] w, output logic e);
        e = 1'b0;
        case (a[5:2])
            4'h1: m_out = w;
            4'h2: m_out[15:0] = (m_out[15:0] & ~w[31:16]) | (w[15:0] & w[31:16]);
            4'h3: m_out[31:16] = (m_out[31:16] & ~w[31:16]) | (w[15:0] & w[31:16]);
            4'h4: m_dir = w;
            4'h5: m_ie = w;
            4'h6: m_itype[31:0] = w;
            4'h7: m_itype[63:32] = w;
            4'h8: m_ifg = m_ifg & ~w;
            4'h9: m_th = w[7:0];
`ifdef GPIO_STRAP_EN
            4'hA: if (w[0]) m_sv = 1'b0;
`endif
            default: e = 1'b1;
        endcase
        m_out8 = m_out[7:0];
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // One APB transfer starting just after a clock edge; commits on the second edge
    task automatic apb(input logic rd, input logic [5:0] a, input logic [31:0] wd, input logic chkpad);
        exp_t e;
        m_level();
        e.rd    = rd;
        e.addr  = a;
        e.irq   = |(m_ifg & m_ie);
        e.pmask = chkpad ? m_dir : '0;
        e.pval  = m_out;
        e.chk8  = rd && (a[5:2] == 4'h1);
        e.data8 = {24'b0, m_out8};
        e.data  = '0;
        if (rd) m_read(a, e.data, e.err);
        else    m_write(a, wd, e.err);
        sbq.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = !rd; PADDR = a; PWDATA = wd;
        cyc(1);
        PENABLE = 1'b1;
        cyc(1);
        PSEL = 1'b0; PENABLE = 1'b0;
        m_level();
    endtask

    task automatic settle(input logic [31:0] v);
        pad_drv = v;
        cyc(SS + int'(m_th) + 4);
        m_events(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [5:0]  a;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; strap_en = 1'b0;
        pad_en = '1; pad_drv = '0;
        m_out = '0; m_dir = '0; m_ie = '0; m_ifg = '0; m_in = '0;
        m_itype = '0; m_th = '0; m_out8 = '0; m_sv = 1'b0; m_sd = '0;
        cyc(3);
        PRESETn = 1'b1;
        cyc(2);

        // Reset values across the whole map, including unmapped words
        for (int i = 0; i < 16; i++) apb(1'b1, 6'(i * 4), '0, 1'b0);

        // Output path
        pad_en = '0;
        apb(1'b0, 6'h10, 32'hFFFF_FFFF, 1'b0);
        apb(1'b0, 6'h04, 32'hDEAD_C0DE, 1'b0);
        apb(1'b0, 6'h0C, 32'h0FF0_ABCD, 1'b0);
        apb(1'b1, 6'h04, '0, 1'b1);
        apb(1'b1, 6'h0C, '0, 1'b1);
        apb(1'b0, 6'h00, 32'h0000_1234, 1'b1);
        apb(1'b1, 6'h3C, '0, 1'b1);
        apb(1'b0, 6'h2C, 32'h0000_0055, 1'b1);
        apb(1'b0, 6'h34, 32'h0000_0055, 1'b1);
        apb(1'b1, 6'h04, '0, 1'b1);
        apb(1'b0, 6'h04, 32'h0000_FFFF, 1'b0);
        apb(1'b1, 6'h04, '0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            v = $urandom();
            a = 6'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: apb(1'b0, 6'h04 | a, v, 1'b0);
                1: apb(1'b0, 6'h08 | a, v, 1'b0);
                2: apb(1'b0, 6'h0C | a, v, 1'b0);
                3: apb(1'b0, 6'h10 | a, v, 1'b0);
                4: apb(1'b1, 6'h10 | a, '0, 1'b1);
                default: apb(1'b1, 6'h04 | a, '0, 1'b1);
            endcase
        end
        apb(1'b0, 6'h10, '0, 1'b0);
        pad_en = '1;
        settle($urandom());
        settle(32'h0000_0000);

        // Debounce latency and glitch rejection at threshold 4
        apb(1'b0, 6'h24, 32'h0000_0004, 1'b0);
        apb(1'b1, 6'h24, '0, 1'b0);
        settle(32'h0000_0000);
        pad_drv = 32'h1234_5678;
        cyc(5);
        apb(1'b1, 6'h00, '0, 1'b0);
        cyc(2);
        m_events(32'h1234_5678);
        apb(1'b1, 6'h00, '0, 1'b0);
        settle(32'h1234_5678);
        pad_drv = 32'hA5A5_0F0F;
        cyc(6);
        m_events(32'hA5A5_0F0F);
        apb(1'b1, 6'h00, '0, 1'b0);
        settle(32'hA5A5_0F0F);
        for (int w = 3; w <= 5; w++) begin
            pad_drv[0] = ~pad_drv[0];
            cyc(w);
            pad_drv[0] = ~pad_drv[0];
            cyc(2);
            if (w == 5) m_events(m_in ^ 32'h1);
            apb(1'b1, 6'h00, '0, 1'b0);
            settle(32'hA5A5_0F0F);
        end
        apb(1'b0, 6'h24, '0, 1'b0);

        // Directed interrupt behaviour
        apb(1'b0, 6'h18, 32'h0000_0004, 1'b0);
        apb(1'b0, 6'h1C, 32'h0000_0000, 1'b0);
        apb(1'b0, 6'h14, 32'h0000_0003, 1'b0);
        settle(32'h0000_0000);
        apb(1'b0, 6'h20, 32'hFFFF_FFFF, 1'b0);
        apb(1'b1, 6'h20, '0, 1'b0);
        settle(32'h0000_0001);
        apb(1'b1, 6'h20, '0, 1'b0);
        apb(1'b0, 6'h20, 32'h0000_0001, 1'b0);
        apb(1'b1, 6'h20, '0, 1'b0);
        settle(32'h0000_0000);
        apb(1'b1, 6'h20, '0, 1'b0);
        pad_drv = 32'h0000_0001;
        cyc(SS);
        apb(1'b0, 6'h20, 32'h0000_0001, 1'b0);
        m_events(32'h0000_0001);
        apb(1'b1, 6'h20, '0, 1'b0);
        settle(32'h0000_0003);
        settle(32'h0000_0001);
        apb(1'b1, 6'h20, '0, 1'b0);
        apb(1'b0, 6'h14, 32'h0000_0000, 1'b0);
        apb(1'b1, 6'h20, '0, 1'b0);
        apb(1'b0, 6'h18, 32'h0000_0030, 1'b0);
        settle(32'h0000_0004);
        apb(1'b0, 6'h20, 32'hFFFF_FFFF, 1'b0);
        apb(1'b1, 6'h20, '0, 1'b0);
        apb(1'b0, 6'h14, 32'h0000_0004, 1'b0);
        apb(1'b1, 6'h20, '0, 1'b0);
        apb(1'b0, 6'h20, 32'h0000_0004, 1'b0);
        apb(1'b1, 6'h20, '0, 1'b0);
        settle(32'h0000_0000);
        apb(1'b0, 6'h20, 32'h0000_0004, 1'b0);
        apb(1'b1, 6'h20, '0, 1'b0);

        // Randomised input/interrupt traffic
        for (int i = 0; i < 60; i++) begin
            v = $urandom();
            a = 6'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: settle(v);
                1: apb(1'b0, 6'h14 | a, v, 1'b0);
                2: apb(1'b0, 6'h18 | a, v, 1'b0);
                3: apb(1'b0, 6'h1C | a, v, 1'b0);
                4: apb(1'b0, 6'h20 | a, v, 1'b0);
                5: apb(1'b1, 6'h00 | a, '0, 1'b0);
                default: apb(1'b1, 6'h20 | a, '0, 1'b0);
            endcase
        end

`ifdef GPIO_STRAP_EN
        apb(1'b0, 6'h14, 32'h0000_0000, 1'b0);
        settle(32'hCAFE_BABE);
        strap_en = 1'b1;
        cyc(1);
        strap_en = 1'b0;
        m_sv = 1'b1;
        m_sd = m_in;
        apb(1'b1, 6'h28, '0, 1'b0);
        apb(1'b1, 6'h2C, '0, 1'b0);
        apb(1'b0, 6'h28, 32'h0000_0001, 1'b0);
        apb(1'b1, 6'h28, '0, 1'b0);
        apb(1'b1, 6'h2C, '0, 1'b0);
`else
        apb(1'b1, 6'h28, '0, 1'b0);
        apb(1'b1, 6'h2C, '0, 1'b0);
`endif

        cyc(3);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain got=%0d exp=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
